// File: rtl/instr_sequencer.sv
// Program sequencer feeding simple_cpu. A host fills a small instruction store.
// On start, the sequencer presents one word at a time to the CPU and holds each
// word for HOLD_CYCLES clocks. It can free-run, single-step, stop on a HALT
// opcode, or stop on an external halt request.
module instr_sequencer #(
    parameter int          INSTR_WIDTH = 20,
    parameter int          PC_BITS     = 4,
    parameter int          HOLD_CYCLES = 3,
    parameter logic [3:0]  HALT_OP     = 4'hF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_wen,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   start,
    input  logic                   step_mode,
    input  logic                   step,
    input  logic                   halt_req,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done
);

    localparam int DEPTH = 1 << PC_BITS;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_STEP, DONE} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       hold_cnt;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    logic [PC_BITS-1:0]     pc_next;
    logic [INSTR_WIDTH-1:0] first_word;
    logic [INSTR_WIDTH-1:0] next_word;
    logic                   first_is_halt;
    logic                   next_is_halt;
    logic                   idle_like;
    logic                   last_hold;
    logic                   to_done;
    logic                   to_wait;
    logic                   advance;

    // Fetch paths and the end-of-word decision shared by ISSUE and WAIT_STEP
    always_comb begin
        pc_next       = pc + 1'b1;
        first_word    = mem[0];
        next_word     = mem[pc_next];
        first_is_halt = (first_word[INSTR_WIDTH-1 -: 4] == HALT_OP);
        next_is_halt  = (next_word[INSTR_WIDTH-1 -: 4] == HALT_OP);
        idle_like     = (state == IDLE) || (state == DONE);
        last_hold     = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));
        to_done       = 1'b0;
        to_wait       = 1'b0;
        advance       = 1'b0;
        if (state == ISSUE && last_hold) begin
            // The store end is a hard stop; pc never wraps to 0.
            if (halt_req || pc == {PC_BITS{1'b1}}) to_done = 1'b1;
            else if (step_mode)                   to_wait = 1'b1;
            else                                  advance = 1'b1;
        end else if (state == WAIT_STEP) begin
            if (halt_req)  to_done = 1'b1;
            else if (step) advance = 1'b1;
        end
    end

    // Host writes are accepted only while no program is running. A start in
    // the same clock still reads the old mem[0] because both use the pre-edge value.
    always_ff @(posedge clk) begin
        if (prog_wen && idle_like) mem[prog_addr] <= prog_data;
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hold_cnt    <= '0;
        end else if (idle_like) begin
            if (start) begin
                pc <= '0;
                if (first_is_halt) begin
                    state       <= DONE;
                    instr_valid <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end else begin
                    state       <= ISSUE;
                    instruction <= first_word;
                    instr_valid <= 1'b1;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    hold_cnt    <= '0;
                end
            end
        end else if (to_done) begin
            state       <= DONE;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
        end else if (to_wait) begin
            // Keep instruction and pc visible while the host decides to step.
            state       <= WAIT_STEP;
            instr_valid <= 1'b0;
        end else if (advance) begin
            pc <= pc_next;
            if (next_is_halt) begin
                // The HALT word itself is never put on the bus.
                state       <= DONE;
                instr_valid <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b1;
            end else begin
                state       <= ISSUE;
                instruction <= next_word;
                instr_valid <= 1'b1;
                hold_cnt    <= '0;
            end
        end else if (state == ISSUE) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer. A reference model runs alongside the DUT
// and is checked every clock. Literal checks pin the timing the model implies.
module tb_instr_sequencer;

    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_wen;
    logic [3:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start, step_mode, step, halt_req;
    logic [19:0] instruction;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        busy, done;

    int n_cmp = 0;
    int n_err = 0;
    int tot_valid = 0;

    instr_sequencer #(.INSTR_WIDTH(20), .PC_BITS(4), .HOLD_CYCLES(HOLD), .HALT_OP(4'hF)) dut (
        .clk(clk), .rst(rst), .prog_wen(prog_wen), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .step_mode(step_mode), .step(step),
        .halt_req(halt_req), .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The model tracks which word is on the bus, how many presentation clocks
    // are left, and whether the run is waiting or finished.
    logic [19:0] smem [16];
    int          m_pc;
    int          m_left;
    bit          m_show, m_wait, m_fin;
    logic [19:0] m_instr;

    function automatic bit is_halt(input logic [19:0] w);
        return w[19:16] == 4'hF;
    endfunction

    task automatic m_next();
        m_pc = m_pc + 1;
        m_wait = 0;
        if (is_halt(smem[m_pc])) begin
            m_show = 0; m_fin = 1;
        end else begin
            m_instr = smem[m_pc]; m_show = 1; m_left = HOLD;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_left = 0; m_show = 0; m_wait = 0; m_fin = 0; m_instr = '0;
        end else begin
            bit quiet;
            quiet = !m_show && !m_wait;
            if (quiet && start) begin
                m_pc = 0;
                if (is_halt(smem[0])) m_fin = 1;
                else begin
                    m_instr = smem[0]; m_show = 1; m_left = HOLD; m_fin = 0;
                end
            end else if (m_show) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (halt_req || m_pc == 15) begin m_show = 0; m_fin = 1; end
                    else if (step_mode)         begin m_show = 0; m_wait = 1; end
                    else                        m_next();
                end
            end else if (m_wait) begin
                if (halt_req)  begin m_wait = 0; m_fin = 1; end
                else if (step) m_next();
            end
            if (quiet && prog_wen) smem[prog_addr] = prog_data;
        end
    end

    // ---------------- compare process ----------------
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cmp("valid", 32'(instr_valid), 32'(m_show));
        cmp("busy",  32'(busy), 32'(m_show || m_wait));
        cmp("done",  32'(done), 32'(m_fin));
        if (m_show || m_wait) begin
            cmp("pc", 32'(pc), 32'(m_pc));
            cmp("instruction", 32'(instruction), 32'(m_instr));
        end
        if (instr_valid) begin
            tot_valid++;
            cmp("halt_never_valid", 32'(instruction[19:16] == 4'hF), 32'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic prog(input int a, input logic [19:0] d);
        prog_wen = 1; prog_addr = 4'(a); prog_data = d;
        tick();
        prog_wen = 0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (!done && n < budget) begin tick(); n++; end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL %s: done not seen within %0d clocks", nm, budget);
        end
    endtask

    task automatic wait_pc(input int want, input string nm);
        int n = 0;
        while (!(instr_valid && pc == 4'(want)) && n < 60) begin tick(); n++; end
        if (!(instr_valid && pc == 4'(want))) begin
            n_cmp++; n_err++;
            $display("FAIL %s: pc %0d not presented in time", nm, want);
        end
    endtask

    initial begin
        int v0;
        rst = 1; prog_wen = 0; prog_addr = '0; prog_data = '0;
        start = 0; step_mode = 0; step = 0; halt_req = 0;
        tick();
        cmp("reset_valid", 32'(instr_valid), 32'd0);
        cmp("reset_pc", 32'(pc), 32'd0);
        cmp("reset_instr", 32'(instruction), 32'd0);
        cmp("reset_busy_done", 32'({busy, done}), 32'd0);
        rst = 0;
        tick();

        // T1: three-word program, free-run
        prog(0, 20'h01234); prog(1, 20'h15678); prog(2, 20'hF0000);
        start = 1; v0 = tot_valid;
        for (int k = 1; k <= 7; k++) begin
            tick();
            start = 0;
            if (k <= 6) begin
                cmp("t1_valid", 32'(instr_valid), 32'd1);
                cmp("t1_pc", 32'(pc), (k <= 3) ? 32'd0 : 32'd1);
                cmp("t1_done_low", 32'(done), 32'd0);
            end else begin
                cmp("t1_done", 32'(done), 32'd1);
                cmp("t1_valid_off", 32'(instr_valid), 32'd0);
            end
        end
        cmp("t1_valid_count", 32'(tot_valid - v0), 32'd6);

        // T2: single-step, and clearing step_mode does not resume
        step_mode = 1; start = 1;
        tick(); start = 0;
        cmp("t2_first", 32'(instruction), 32'h01234);
        tick(); tick(); tick();
        cmp("t2_wait_valid", 32'(instr_valid), 32'd0);
        cmp("t2_wait_pc", 32'(pc), 32'd0);
        cmp("t2_wait_busy", 32'(busy), 32'd1);
        step_mode = 0;
        tick(); tick();
        cmp("t2_no_resume", 32'(instr_valid), 32'd0);
        step = 1; tick(); step = 0;
        cmp("t2_step_valid", 32'(instr_valid), 32'd1);
        cmp("t2_step_pc", 32'(pc), 32'd1);
        cmp("t2_step_instr", 32'(instruction), 32'h15678);
        tick(); tick(); tick();
        cmp("t2_done", 32'(done), 32'd1);

        // T3: full store, no wrap past pc 15
        for (int i = 0; i < 16; i++) prog(i, 20'h10000 | 20'(i * 20'h00111));
        start = 1; v0 = tot_valid;
        tick(); start = 0;
        wait_done(80, "t3");
        cmp("t3_valid_count", 32'(tot_valid - v0), 32'd48);
        cmp("t3_end_pc", 32'(pc), 32'd15);
        tick(); tick();
        cmp("t3_no_wrap", 32'(instr_valid), 32'd0);

        // T4: halt_req on the last hold clock of pc 0
        start = 1; v0 = tot_valid;
        tick(); start = 0;
        tick(); tick();
        halt_req = 1; tick(); halt_req = 0;
        cmp("t4_done", 32'(done), 32'd1);
        tick(); tick();
        cmp("t4_valid_count", 32'(tot_valid - v0), 32'd3);

        // T5: async reset while issuing pc 2, then rerun from pc 0
        start = 1; tick(); start = 0;
        wait_pc(2, "t5");
        rst = 1; #1;
        cmp("t5_rst_valid", 32'(instr_valid), 32'd0);
        cmp("t5_rst_pc", 32'(pc), 32'd0);
        cmp("t5_rst_instr", 32'(instruction), 32'd0);
        cmp("t5_rst_busy", 32'(busy), 32'd0);
        tick(); rst = 0; tick();
        start = 1; tick(); start = 0;
        cmp("t5_rerun_pc", 32'(pc), 32'd0);
        cmp("t5_rerun_instr", 32'(instruction), 32'h10000);

        // T6: host write while busy is dropped
        tick();
        prog(1, 20'h0BEEF);
        wait_done(80, "t6a");
        start = 1; tick(); start = 0;
        wait_pc(1, "t6");
        cmp("t6_mem1_kept", 32'(instruction), 32'h10111);
        wait_done(80, "t6b");

        // T7: start with a same-clock write to addr 0 reads the old word
        start = 1; prog_wen = 1; prog_addr = 4'd0; prog_data = 20'h2AAAA;
        tick(); start = 0; prog_wen = 0;
        cmp("t7_old_word", 32'(instruction), 32'h10000);
        wait_done(80, "t7");
        start = 1; tick(); start = 0;
        cmp("t7_new_word", 32'(instruction), 32'h2AAAA);
        wait_done(80, "t7b");

        // T8: HALT word at address 0 goes straight to DONE
        tick();
        prog(0, 20'hF1234);
        start = 1; tick(); start = 0;
        cmp("t8_done", 32'(done), 32'd1);
        cmp("t8_valid", 32'(instr_valid), 32'd0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program sequencer placed in front of simple_cpu. Holds a small instruction store loaded by a host port, then drives the CPU's 20-bit instruction input one word at a time.
- Each word is held stable for a fixed number of clocks so the CU can finish it.
- Supports free-run and single-step modes, a halt opcode, and an external halt request.

Parameters:
- INSTR_WIDTH, 20, instruction word width (matches CPU).
- PC_BITS, 4, store depth is 2^PC_BITS words (16).
- HOLD_CYCLES, 3, clocks each instruction is presented (must be >= 1).
- HALT_OP, 4'hF, value of instruction[INSTR_WIDTH-1:INSTR_WIDTH-4] that terminates the program.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- prog_wen  in  1  host write enable into the store.
- prog_addr  in  PC_BITS  host write address.
- prog_data  in  INSTR_WIDTH  host write data.
- start  in  1  begin execution at pc 0 (level sampled, accepted in IDLE/DONE).
- step_mode  in  1  1 = wait for step after each instruction.
- step  in  1  advance one instruction in step mode (single-cycle pulse).
- halt_req  in  1  stop after the current instruction completes.
- instruction  out  INSTR_WIDTH  word driven to the CPU.
- instr_valid  out  1  high while instruction is being presented.
- pc  out  PC_BITS  address of the word on instruction.
- busy  out  1  high in ISSUE and WAIT_STEP.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, any state): state IDLE, pc=0, instruction=0, instr_valid=0, busy=0, done=0, hold counter=0. Store contents are NOT cleared.
- Store: synchronous write on clk when prog_wen=1 and state is IDLE or DONE. Writes in ISSUE/WAIT_STEP are ignored.
- States: IDLE, ISSUE, WAIT_STEP, DONE. All outputs are registered.
- IDLE/DONE, start=1: pc<=0 and load mem[0]. If its opcode field == HALT_OP, go to DONE with instr_valid=0. Otherwise go to ISSUE with instruction<=mem[0], instr_valid<=1, counter<=0.
- Start latency: 1 clock from start sampled to instr_valid=1.
- A simultaneous prog_wen to addr 0 with start: start reads the old mem[0].
- ISSUE:
  - instruction and pc are held stable for exactly HOLD_CYCLES clocks with instr_valid=1.
  - On the last hold clock, the next action is chosen in this priority order:
    1. halt_req=1, or pc == 2^PC_BITS-1 (no wrap): go to DONE, instr_valid<=0.
    2. step_mode=1: go to WAIT_STEP, instr_valid<=0, instruction held.
    3. Otherwise: pc<=pc+1 and fetch mem[pc+1]. If its opcode is HALT_OP, go to DONE. Else reissue back-to-back with instr_valid held at 1 and counter reset.
  - halt_req is sampled only on the last hold clock; a pulse earlier in the hold window is lost.
- WAIT_STEP:
  - step=1: advance exactly as in rule 3 above.
  - halt_req=1: go to DONE. halt_req wins over a simultaneous step.
  - Clearing step_mode while in WAIT_STEP does not resume execution; a step pulse is still required.
- DONE: done=1, busy=0, instr_valid=0; instruction and pc keep their last values. start re-runs from pc 0.
- HALT_OP words are never presented with instr_valid=1.

Test Plan:
- Load mem[0..2]=20'h01234, 20'h15678, 20'hF0000; start pulse, step_mode=0, HOLD_CYCLES=3 -> instr_valid high for 6 consecutive clocks, pc 0 for 3 clocks then 1 for 3 clocks; done=1 on the 7th clock after start; the HALT word is never valid.
- Same program with step_mode=1 -> instruction 20'h01234 valid for 3 clocks, then WAIT_STEP (instr_valid=0, pc=0); a step pulse -> 20'h15678 valid 1 clock later with pc=1.
- Fill all 16 words with non-halt data and run -> pc reaches 15, 48 valid clocks total, then DONE with pc=15 (no wrap to 0).
- Assert halt_req on the last hold clock of pc=0 in free-run -> DONE next clock; pc=1 is never issued.
- Assert rst during ISSUE at pc=2 -> outputs return to reset values immediately; a following start re-executes the unchanged program from pc 0.
- Drive prog_wen to addr 1 while busy -> after DONE, a re-run shows the original mem[1] value.
